// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional statistics counters are enabled with MEM_RESPONDER_STATS_EN.
package mem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [31:0]       addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// DEPTH x 32-bit word storage: synchronous write, combinational read, no reset.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Valid/ready data-memory target with fixed wait states and address error flagging.
// Define MEM_RESPONDER_STATS_EN to add saturating load/store/error response counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
            $error("mem_responder: illegal WAIT_CYCLES or DEPTH");
        end
    endgenerate

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    req_t              hold;
    logic              addr_err;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign addr_err = (hold.addr[1:0] != 2'b00) || (hold.addr[31:2] >= 30'(DEPTH));
    // The access itself happens on the first edge spent in RESP, before resp_valid rises.
    assign mem_we   = (state == RESP) && !resp_valid && hold.write && !addr_err;

    mem_responder_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (hold.addr[AW+1:2]),
        .wdata (hold.wdata),
        .raddr (hold.addr[AW+1:2]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hold       <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        hold      <= '{write: req_write, addr: req_addr, wdata: req_wdata};
                        req_ready <= 1'b0;
                        cnt       <= CNT_INIT;
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                RESP: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= addr_err;
                        resp_rdata <= (addr_err || hold.write) ? '0 : mem_rdata;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (resp_valid && resp_ready) begin
            if (resp_err)        stat_errs   <= sat_inc(stat_errs);
            else if (hold.write) stat_stores <= sat_inc(stat_stores);
            else                 stat_loads  <= sat_inc(stat_loads);
        end
    end
`endif

endmodule
